// File: rtl/mdu_divider.sv
// mdu_divider: radix-2 restoring divider behind dividend/divisor/dout streams.
// Define DIV_DOUT_TREADY_EN to add m_axis_dout_tready backpressure on results.
module mdu_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
`ifdef DIV_DOUT_TREADY_EN
  input  logic               m_axis_dout_tready,
`endif
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic             cap_a;
  logic             cap_b;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] bq;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             sign_q;
  logic             sign_r;
  logic             bz;
  logic [CW-1:0]    cnt;

  logic             hs_a;
  logic             hs_b;
  logic             have_a;
  logic             have_b;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic             done_ack;

  always_comb begin
    hs_a    = s_axis_dividend_tvalid & s_axis_dividend_tready;
    hs_b    = s_axis_divisor_tvalid & s_axis_divisor_tready;
    have_a  = cap_a | hs_a;
    have_b  = cap_b | hs_b;
    a_val   = hs_a ? s_axis_dividend_tdata : dvd_q;
    b_val   = hs_b ? s_axis_divisor_tdata : dvs_q;
    neg_a   = SIGNED && a_val[WIDTH-1];
    neg_b   = SIGNED && b_val[WIDTH-1];
    a_mag   = neg_a ? -a_val : a_val;
    b_mag   = neg_b ? -b_val : b_val;
    // trial remainder is WIDTH+1 bits; the kept remainder always fits WIDTH
    shifted = {r, q[WIDTH-1]};
    ge      = shifted >= {1'b0, bq};
    sub     = shifted[WIDTH-1:0] - bq;
  end

`ifdef DIV_DOUT_TREADY_EN
  assign done_ack = m_axis_dout_tready;
`else
  assign done_ack = 1'b1;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state                  <= IDLE;
      s_axis_dividend_tready <= 1'b0;
      s_axis_divisor_tready  <= 1'b0;
      m_axis_dout_tvalid     <= 1'b0;
      m_axis_dout_tdata      <= '0;
      cap_a                  <= 1'b0;
      cap_b                  <= 1'b0;
      dvd_q                  <= '0;
      dvs_q                  <= '0;
      bq                     <= '0;
      q                      <= '0;
      r                      <= '0;
      sign_q                 <= 1'b0;
      sign_r                 <= 1'b0;
      bz                     <= 1'b0;
      cnt                    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hs_a) begin
            dvd_q <= s_axis_dividend_tdata;
            cap_a <= 1'b1;
          end
          if (hs_b) begin
            dvs_q <= s_axis_divisor_tdata;
            cap_b <= 1'b1;
          end
          if (have_a && have_b) begin
            state                  <= CALC;
            s_axis_dividend_tready <= 1'b0;
            s_axis_divisor_tready  <= 1'b0;
            q                      <= a_mag;
            bq                     <= b_mag;
            r                      <= '0;
            cnt                    <= '0;
            sign_q                 <= neg_a ^ neg_b;
            sign_r                 <= neg_a;
            bz                     <= (b_val == '0);
          end else begin
            s_axis_dividend_tready <= !have_a;
            s_axis_divisor_tready  <= !have_b;
          end
        end
        CALC: begin
          r   <= ge ? sub : shifted[WIDTH-1:0];
          q   <= (q << 1) | WIDTH'(ge);
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // divide by zero reports the raw dividend, no sign correction
          if (bz) begin
            q <= '1;
            r <= dvd_q;
          end else begin
            if (sign_q) q <= -q;
            if (sign_r) r <= -r;
          end
          state <= DONE;
        end
        DONE: begin
          if (!m_axis_dout_tvalid) begin
            m_axis_dout_tvalid <= 1'b1;
            m_axis_dout_tdata  <= {q, r};
          end else if (done_ack) begin
            m_axis_dout_tvalid     <= 1'b0;
            state                  <= IDLE;
            s_axis_dividend_tready <= 1'b1;
            s_axis_divisor_tready  <= 1'b1;
            cap_a                  <= 1'b0;
            cap_b                  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: directed checks of signed and unsigned mdu_divider instances.
// Both instances share stimulus; each test compares against hand-computed values.
`timescale 1ns/1ps
module tb_mdu_divider;
  localparam int W = 32;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           a_valid = 1'b0;
  logic           b_valid = 1'b0;
  logic [W-1:0]   a_data = '0;
  logic [W-1:0]   b_data = '0;
`ifdef DIV_DOUT_TREADY_EN
  logic           dout_ready = 1'b1;
`endif
  logic           s_a_ready;
  logic           s_b_ready;
  logic           s_valid;
  logic [2*W-1:0] s_data;
  logic           u_a_ready;
  logic           u_b_ready;
  logic           u_valid;
  logic [2*W-1:0] u_data;

  int compared = 0;
  int mismatched = 0;

  always #5 aclk = ~aclk;

  mdu_divider #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (a_valid),
    .s_axis_dividend_tready (s_a_ready),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_divisor_tvalid  (b_valid),
    .s_axis_divisor_tready  (s_b_ready),
    .s_axis_divisor_tdata   (b_data),
`ifdef DIV_DOUT_TREADY_EN
    .m_axis_dout_tready     (dout_ready),
`endif
    .m_axis_dout_tvalid     (s_valid),
    .m_axis_dout_tdata      (s_data)
  );

  mdu_divider #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (a_valid),
    .s_axis_dividend_tready (u_a_ready),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_divisor_tvalid  (b_valid),
    .s_axis_divisor_tready  (u_b_ready),
    .s_axis_divisor_tdata   (b_data),
`ifdef DIV_DOUT_TREADY_EN
    .m_axis_dout_tready     (dout_ready),
`endif
    .m_axis_dout_tvalid     (u_valid),
    .m_axis_dout_tdata      (u_data)
  );

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(s_a_ready && s_b_ready && u_a_ready && u_b_ready) && n < 100) begin
      @(posedge aclk); #1;
      n++;
    end
  endtask

  // Present both operands together; lat = edges from edge 0 to tvalid, -1 on timeout
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    wait_ready();
    a_data = a; b_data = b;
    a_valid = 1'b1; b_valid = 1'b1;
    @(posedge aclk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge aclk); #1;
      if (s_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #12;
    compared++;
    if ({s_a_ready, s_b_ready, u_a_ready, u_b_ready} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ready: got %b want 0000", {s_a_ready, s_b_ready, u_a_ready, u_b_ready});
    end
    compared++;
    if ({s_valid, u_valid} !== 2'b00 || s_data !== 64'h0 || u_data !== 64'h0) begin
      mismatched++;
      $display("FAIL reset_dout: got v=%b%b s=%h u=%h want 0", s_valid, u_valid, s_data, u_data);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    compared++;
    if ({s_a_ready, s_b_ready} !== 2'b00) begin
      mismatched++;
      $display("FAIL release_early_ready: got %b want 00", {s_a_ready, s_b_ready});
    end
    @(posedge aclk); #1;
    compared++;
    if ({s_a_ready, s_b_ready, u_a_ready, u_b_ready} !== 4'b1111) begin
      mismatched++;
      $display("FAIL release_ready: got %b want 1111", {s_a_ready, s_b_ready, u_a_ready, u_b_ready});
    end
  endtask

  task automatic test_unsigned();
    int lat;
    op(32'd100, 32'd7, lat);
    compared++;
    if (lat != 34) begin
      mismatched++;
      $display("FAIL unsigned_latency: got %0d want 34", lat);
    end
    compared++;
    if (u_data !== 64'h0000000E_00000002) begin
      mismatched++;
      $display("FAIL unsigned_data: got %h want 0000000e00000002", u_data);
    end
    compared++;
    if (s_data !== 64'h0000000E_00000002) begin
      mismatched++;
      $display("FAIL signed_pos_data: got %h want 0000000e00000002", s_data);
    end
    @(posedge aclk); #1;
    compared++;
    if (u_valid !== 1'b0 || s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL pulse_width: got %b%b want 00", s_valid, u_valid);
    end
    compared++;
    if (u_data !== 64'h0000000E_00000002) begin
      mismatched++;
      $display("FAIL data_hold: got %h want 0000000e00000002", u_data);
    end
    compared++;
    if ({u_a_ready, u_b_ready} !== 2'b11) begin
      mismatched++;
      $display("FAIL ready_after_done: got %b want 11", {u_a_ready, u_b_ready});
    end
  endtask

  task automatic test_signed();
    logic [W-1:0]   av [3];
    logic [W-1:0]   bv [3];
    logic [2*W-1:0] ev [3];
    int lat;
    av = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    bv = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    ev = '{64'hFFFFFFFD_FFFFFFFF, 64'hFFFFFFFD_00000001, 64'h00000003_FFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      op(av[i], bv[i], lat);
      compared++;
      if (s_data !== ev[i] || lat != 34) begin
        mismatched++;
        $display("FAIL signed[%0d]: got %h lat %0d want %h lat 34", i, s_data, lat, ev[i]);
      end
    end
    op(32'hFFFF_FFF9, 32'd2, lat);
    compared++;
    if (u_data !== 64'h7FFFFFFC_00000001) begin
      mismatched++;
      $display("FAIL unsigned_big: got %h want 7ffffffc00000001", u_data);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   av [4];
    logic [W-1:0]   bv [4];
    logic [2*W-1:0] es [4];
    logic [2*W-1:0] eu [4];
    int lat;
    av = '{32'h8000_0000, 32'd5, 32'hFFFF_FFF9, 32'd3};
    bv = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5};
    es = '{64'h80000000_00000000, 64'hFFFFFFFF_00000005,
           64'hFFFFFFFF_FFFFFFF9, 64'h00000000_00000003};
    eu = '{64'h00000000_80000000, 64'hFFFFFFFF_00000005,
           64'hFFFFFFFF_FFFFFFF9, 64'h00000000_00000003};
    for (int i = 0; i < 4; i++) begin
      op(av[i], bv[i], lat);
      compared++;
      if (s_data !== es[i] || lat != 34) begin
        mismatched++;
        $display("FAIL corner_s[%0d]: got %h lat %0d want %h lat 34", i, s_data, lat, es[i]);
      end
      compared++;
      if (u_data !== eu[i]) begin
        mismatched++;
        $display("FAIL corner_u[%0d]: got %h want %h", i, u_data, eu[i]);
      end
    end
  endtask

  task automatic test_split();
    int lat;
    logic stuck;
    wait_ready();
    a_data = 32'h1234_5678;
    a_valid = 1'b1;
    @(posedge aclk); #1;
    a_valid = 1'b0;
    compared++;
    if ({s_a_ready, s_b_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL split_ready: got %b want 01", {s_a_ready, s_b_ready});
    end
    stuck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      if (s_a_ready !== 1'b0 || s_valid !== 1'b0) stuck = 1'b1;
    end
    compared++;
    if (stuck !== 1'b0) begin
      mismatched++;
      $display("FAIL split_hold: got dividend_tready/tvalid high want 0");
    end
    b_data = 32'h10;
    b_valid = 1'b1;
    @(posedge aclk); #1;
    b_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge aclk); #1;
      if (s_valid) begin
        lat = i;
        break;
      end
    end
    compared++;
    if (lat != 34 || s_data !== 64'h01234567_00000008 || u_data !== 64'h01234567_00000008) begin
      mismatched++;
      $display("FAIL split_result: got s=%h u=%h lat %0d want 0123456700000008 lat 34", s_data, u_data, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    wait_ready();
    a_data = 32'd100; b_data = 32'd7;
    a_valid = 1'b1; b_valid = 1'b1;
    @(posedge aclk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    compared++;
    if ({s_a_ready, s_b_ready, s_valid, u_valid} !== 4'b0000 || s_data !== 64'h0 || u_data !== 64'h0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got r=%b%b v=%b s=%h u=%h want all 0",
               s_a_ready, s_b_ready, s_valid, s_data, u_data);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge aclk); #1;
      if (s_valid || u_valid || s_a_ready) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_quiet: got activity during reset want none");
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    compared++;
    if ({s_a_ready, s_b_ready, u_a_ready, u_b_ready} !== 4'b1111) begin
      mismatched++;
      $display("FAIL midreset_ready: got %b want 1111", {s_a_ready, s_b_ready, u_a_ready, u_b_ready});
    end
    op(32'd9, 32'd3, lat);
    compared++;
    if (lat != 34 || s_data !== 64'h00000003_00000000) begin
      mismatched++;
      $display("FAIL midreset_fresh: got %h lat %0d want 0000000300000000 lat 34", s_data, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    wait_ready();
    a_data = 32'd1000; b_data = 32'd10;
    a_valid = 1'b1; b_valid = 1'b1;
    @(posedge aclk); #1;
    a_data = 32'd200; b_data = 32'd7;
    t1 = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge aclk); #1;
      if (s_valid) begin
        t1 = i;
        break;
      end
    end
    compared++;
    if (t1 != 34 || s_data !== 64'h00000064_00000000) begin
      mismatched++;
      $display("FAIL b2b_first: got %h lat %0d want 0000006400000000 lat 34", s_data, t1);
    end
    @(posedge aclk); #1;
    compared++;
    if ({s_valid, s_a_ready, s_b_ready} !== 3'b011) begin
      mismatched++;
      $display("FAIL b2b_reopen: got v/r=%b want 011", {s_valid, s_a_ready, s_b_ready});
    end
    @(posedge aclk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    compared++;
    if ({s_a_ready, s_b_ready} !== 2'b00) begin
      mismatched++;
      $display("FAIL b2b_accept: got %b want 00", {s_a_ready, s_b_ready});
    end
    t2 = -1;
    for (int i = 3; i <= 100; i++) begin
      @(posedge aclk); #1;
      if (s_valid) begin
        t2 = i;
        break;
      end
    end
    compared++;
    if (t2 != 36 || s_data !== 64'h0000001C_00000004) begin
      mismatched++;
      $display("FAIL b2b_second: got %h spacing %0d want 0000001c00000004 spacing 36", s_data, t2);
    end
  endtask

`ifdef DIV_DOUT_TREADY_EN
  task automatic test_backpressure();
    int lat;
    logic bad;
    dout_ready = 1'b0;
    op(32'd50, 32'd5, lat);
    compared++;
    if (lat != 34) begin
      mismatched++;
      $display("FAIL bp_latency: got %0d want 34", lat);
    end
    bad = 1'b0;
    repeat (3) begin
      @(posedge aclk); #1;
      if (s_valid !== 1'b1 || s_data !== 64'h0000000A_00000000) bad = 1'b1;
    end
    compared++;
    if (bad !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_hold: got v=%b d=%h want 1 0000000a00000000", s_valid, s_data);
    end
    dout_ready = 1'b1;
    @(posedge aclk); #1;
    compared++;
    if (s_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: got %b want 0", s_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_split();
    test_reset_mid();
    test_back_to_back();
`ifdef DIV_DOUT_TREADY_EN
    test_backpressure();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Multi-cycle radix-2 restoring integer divider; the responder side of the dividend/divisor/dout stream handshake that the EXE stage drives for DIV/DIVU.
- Accepts dividend and divisor on two independent slave channels and returns {quotient, remainder} on one master channel.
- One instance per signedness (SIGNED=1 for DIV, SIGNED=0 for DIVU), sitting beside the EXE stage. Drop-in for the vendor divider IP port list.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- SIGNED, 1, 1 = two's-complement divide, 0 = unsigned divide.

Ports:
- aclk  in  1  clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend accepted when valid&ready.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor accepted when valid&ready.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- m_axis_dout_tvalid  out  1  result valid.
- m_axis_dout_tdata  out  2*WIDTH  [2W-1:W] quotient, [W-1:0] remainder.

Behaviour:
- Reset (async assert, sync release): both treadys=0, m_axis_dout_tvalid=0, m_axis_dout_tdata=0, state IDLE, capture flags cleared.
- All outputs are registered. Both treadys rise on the first aclk edge after aresetn deasserts.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - Each channel handshakes independently and latches its tdata on valid&ready.
  - That channel's tready drops the cycle after its capture.
  - Both channels may handshake in the same cycle.
  - When both operands are held, go to CALC. Call the edge that completes the second capture edge 0.
- CALC:
  - SIGNED=1: operate on absolute values, and record sign_q = sign(dividend) ^ sign(divisor) and sign_r = sign(dividend).
  - One quotient bit per cycle, MSB first, WIDTH cycles (edges 1..WIDTH). Uses a WIDTH+1 bit partial remainder.
  - treadys stay 0.
- FIX (edge WIDTH+1):
  - Conditional two's-complement negation of quotient by sign_q and remainder by sign_r. Identity when SIGNED=0.
- DONE (edge WIDTH+2):
  - m_axis_dout_tvalid=1 for exactly one cycle and tdata is loaded. Latency is WIDTH+2 cycles after edge 0.
  - Next edge: tvalid=0, state IDLE, treadys=1, capture flags cleared.
  - tdata holds its value until the next result.
- Division semantics: truncate toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- Divisor zero: no trap. quotient = all ones, remainder = dividend as given (raw, no sign fix). Same latency.
- Signed overflow (SIGNED=1, dividend = 2^(W-1) as a negative, divisor = -1): quotient = 0x80000000 (for W=32), remainder = 0. No flag.
- Operand valids while busy are ignored (tready=0). Upstream holds tdata/tvalid until its handshake.
- aresetn asserted mid-operation aborts immediately: no tvalid is produced and partial operands are discarded.

Optional Feature:
- DIV_DOUT_TREADY_EN adds port m_axis_dout_tready (in, 1).
- With the macro:
  - DONE holds tvalid=1 and tdata stable until tvalid&tready.
  - Returns to IDLE on the edge that completes the handshake.
  - If tready is already 1 on entry, behaviour matches the single-pulse case.
- Without the macro: no tready port; tvalid is a one-cycle pulse with no backpressure.

Test Plan:
- Unsigned basic: SIGNED=0, dividend 100 and divisor 7 in the same cycle -> at edge 34, tvalid=1 for one cycle, tdata=0x0000000E_00000002.
- Signed signs: SIGNED=1, -7/2 -> tdata=0xFFFFFFFD_FFFFFFFF; then 7/-2 -> 0xFFFFFFFD_00000001; then -7/-2 -> 0x00000003_FFFFFFFF.
- Corners, SIGNED=1:
  - 0x80000000 / 0xFFFFFFFF -> 0x80000000_00000000.
  - 5 / 0 -> 0xFFFFFFFF_00000005.
- Split handshake: dividend 0x12345678 at cycle 0, divisor 0x10 at cycle 5.
  - dividend_tready=0 from cycle 1.
  - tvalid at 34 cycles after the divisor edge.
  - tdata=0x01234567_00000008.
- Reset mid-CALC: assert aresetn=0 at edge 10.
  - All outputs go to 0 asynchronously; no tvalid appears.
  - Both treadys=1 one edge after release; a fresh 9/3 returns 0x00000003_00000000.
- Back-to-back: second operand pair presented with tvalid high continuously -> accepted the edge after the first result's tvalid pulse; valid pulses are spaced WIDTH+4 cycles apart. With DIV_DOUT_TREADY_EN and tready held 0 for 3 cycles, tvalid/tdata stay stable across those cycles.
